org_line_loader: RTL and testbench

Upstream fill stage for the 32-pixel-line original-pixel buffer (the single-port line-in/parallel-out memory). Accepts one 64x64 LCU of 4:2:0 original pixels as an 8-pixel-per-beat raster stream, packs every four beats into one 32-pixel line and issues one port-A line write per line. Writes are held off while the consumer owns the memory, because the buffer is single-port.

---
 rtl/org_line_loader_if.sv | 33 +++
 rtl/org_line_loader.sv | 185 ++++++++++++++++++
 tb/tb_org_line_loader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/org_line_loader_if.sv
// Bundle of the pixel-stream and port-A line-write signals of the original-pixel line loader.
// Latency: none (wires only).
// Backpressure: pix_ready from the loader, rd_busy from the buffer consumer.
//
// Signals:
//   pix_valid / pix_data / pix_ready : 8-pixel raster beat stream, leftmost pixel in MSBs
//   rd_busy                          : consumer owns the single-port buffer this cycle
//   mem_wen / mem_addr / mem_wdata   : port-A line write, pixel 0 in MSBs
// Modports: slave = the loader, master = the stream source / buffer side.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

interface org_line_loader_if;
    logic                         pix_valid;
    logic [`PIXEL_WIDTH*8-1:0]    pix_data;
    logic                         pix_ready;
    logic                         rd_busy;
    logic                         mem_wen;
    logic [7:0]                   mem_addr;
    logic [`PIXEL_WIDTH*32-1:0]   mem_wdata;

    modport master (
        output pix_valid, pix_data, rd_busy,
        input  pix_ready, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  pix_valid, pix_data, rd_busy,
        output pix_ready, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/org_line_loader.sv
// Packs a 64x64 4:2:0 LCU raster stream (8 px/beat) into 32-px line writes of the original-pixel buffer.
// Latency: a line write is issued the cycle after its 4th beat is accepted (later if the consumer is reading).
// Backpressure: the 4th beat of a line stalls only while the previous line is still pending behind rd_busy.
//
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   start_i           : one-cycle pulse starting a load, honoured only when idle
//   lif (slave)       : pixel beat stream in, port-A line write out, rd_busy in
//   busy_o            : load in progress (cycle after start through the done cycle)
//   done_o            : one-cycle pulse after the final line write

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module org_line_loader (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    org_line_loader_if.slave   lif,
    output logic               busy_o,
    output logic               done_o
);

    localparam int BEAT_W = `PIXEL_WIDTH * 8;
    localparam int LINE_W = `PIXEL_WIDTH * 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LUMA,
        S_CB,
        S_CR,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          beat_cnt_q;
    logic [5:0]          row_q;
    logic                half_q;
    logic [BEAT_W-1:0]   asm_q [0:2];
    logic                pend_q, pend_d;
    logic [7:0]          waddr_q;
    logic [LINE_W-1:0]   wdata_q;

    logic                in_stream;
    logic                pix_ready;
    logic                accept;
    logic                line_done;
    logic                wen;
    logic                last_luma;
    logic                last_chroma;
    logic                enter_stream;
    logic [7:0]          line_addr;

    // ------------------------------------------------------------------
    // Handshake and write issue
    // ------------------------------------------------------------------
    always_comb begin
        in_stream = (state_q == S_LUMA) || (state_q == S_CB) || (state_q == S_CR);
        // Only a line-completing beat needs the write register free; earlier
        // beats go to the assembly register and can always be taken.
        pix_ready = in_stream && !((beat_cnt_q == 2'd3) && pend_q && lif.rd_busy);
        accept    = lif.pix_valid && pix_ready;
        line_done = accept && (beat_cnt_q == 2'd3);
        // A reset cycle never writes: a pending line is dropped, not flushed.
        wen       = pend_q && !lif.rd_busy && !rst;
        // A line loading on the same edge as the drain keeps pend set.
        pend_d    = line_done || (pend_q && !wen);

        last_luma   = line_done && (state_q == S_LUMA) && half_q && (row_q == 6'd63);
        last_chroma = line_done && (row_q[4:0] == 5'd31);
    end

    // Line address: luma interleaves the left/right halves of rows 0-31 into
    // 0x00-0x3F and rows 32-63 into 0x40-0x7F; Cb and Cr follow at 0x80/0xA0.
    always_comb begin
        line_addr = 8'h00;
        case (state_q)
            S_LUMA:  line_addr = {1'b0, row_q[5], half_q, row_q[4:0]};
            S_CB:    line_addr = {3'b100, row_q[4:0]};
            S_CR:    line_addr = {3'b101, row_q[4:0]};
            default: line_addr = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i)     state_d = S_LUMA;
            S_LUMA:  if (last_luma)   state_d = S_CB;
            S_CB:    if (last_chroma) state_d = S_CR;
            S_CR:    if (last_chroma) state_d = S_FLUSH;
            // Leave as soon as the last line drains, so done follows the final
            // write by exactly one cycle.
            S_FLUSH: if (!pend_d)     state_d = S_DONE;
            S_DONE:                   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
        enter_stream = (state_d != state_q) &&
                       ((state_d == S_LUMA) || (state_d == S_CB) || (state_d == S_CR));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= 2'd0;
            row_q      <= 6'd0;
            half_q     <= 1'b0;
        end else if (enter_stream) begin
            beat_cnt_q <= 2'd0;
            row_q      <= 6'd0;
            half_q     <= 1'b0;
        end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + 2'd1;
            if (beat_cnt_q == 2'd3) begin
                if (state_q == S_LUMA) begin
                    // Luma rows are two half lines: advance the row after the right half.
                    half_q <= ~half_q;
                    if (half_q) begin
                        row_q <= row_q + 6'd1;
                    end
                end else begin
                    row_q <= row_q + 6'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: assembly register and write register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q[0] <= '0;
            asm_q[1] <= '0;
            asm_q[2] <= '0;
        end else if (accept) begin
            case (beat_cnt_q)
                2'd0:    asm_q[0] <= lif.pix_data;
                2'd1:    asm_q[1] <= lif.pix_data;
                2'd2:    asm_q[2] <= lif.pix_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 1'b0;
            waddr_q <= 8'h00;
            wdata_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (line_done) begin
                waddr_q <= line_addr;
                wdata_q <= {asm_q[0], asm_q[1], asm_q[2], lif.pix_data};
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign lif.pix_ready = pix_ready;
    assign lif.mem_wen   = wen;
    assign lif.mem_addr  = waddr_q;
    assign lif.mem_wdata = wdata_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_org_line_loader.sv
// Randomised self-checking bench for org_line_loader against a line-level reference model.
// Drives inputs #1 after the rising edge, samples outputs on the falling edge.
// Consumer reads (rd_busy) are either forced, random, or absent depending on the scenario.

module tb_org_line_loader;

    logic clk;
    logic rst;
    logic start;
    logic busy_o;
    logic done_o;

    org_line_loader_if ifc ();

    org_line_loader dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .lif     (ifc),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc = 0;
    int done_cnt  = 0;
    bit first_chk = 1'b0;
    bit abort     = 1'b0;
    bit busy_force = 1'b0;
    bit busy_rand_en = 1'b0;
    bit busy_rnd  = 1'b0;

    logic [63:0]  beats [768];
    logic [7:0]   got_addr [$];
    logic [255:0] got_data [$];

    assign ifc.rd_busy = busy_force | busy_rnd;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        busy_rnd = busy_rand_en && ($urandom_range(0, 3) == 0);
    end

    // Write monitor / scoreboard capture
    always @(negedge clk) begin
        if (ifc.mem_wen === 1'b1) begin
            got_addr.push_back(ifc.mem_addr);
            got_data.push_back(ifc.mem_wdata);
            chk("wen_while_rd_busy", 256'(ifc.rd_busy), 256'(0));
        end
        if (done_o === 1'b1) done_cnt++;
        if (first_chk && (cyc == start_cyc + 1)) begin
            chk("ready_after_start", 256'(ifc.pix_ready), 256'(1));
            chk("busy_after_start", 256'(busy_o), 256'(1));
            first_chk = 1'b0;
        end
    end

    // Reference model: line L is beats 4L..4L+3; luma lines alternate
    // left/right halves of one row, chroma lines land at 0x80 + (L - 128).
    function automatic logic [7:0] exp_addr(input int l);
        int row;
        int half;
        if (l < 128) begin
            row  = l / 2;
            half = l % 2;
            return 8'((row / 32) * 64 + half * 32 + (row % 32));
        end
        return 8'(l);
    endfunction

    function automatic logic [255:0] exp_data(input int l);
        return {beats[4*l], beats[4*l+1], beats[4*l+2], beats[4*l+3]};
    endfunction

    task automatic fill_beats(input bit rnd);
        for (int i = 0; i < 768; i++) begin
            if (rnd) begin
                beats[i] = {$urandom, $urandom};
            end else begin
                for (int b = 0; b < 8; b++) beats[i][63-8*b -: 8] = 8'(8*i + b);
            end
        end
    endtask

    task automatic compare_sb(input int n);
        chk("write_count", 256'(got_addr.size()), 256'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            chk($sformatf("addr[%0d]", i), 256'(got_addr[i]), 256'(exp_addr(i)));
            chk($sformatf("data[%0d]", i), got_data[i], exp_data(i));
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 of the cycle after start.
    task automatic start_load();
        got_addr.delete();
        got_data.delete();
        done_cnt  = 0;
        abort     = 1'b0;
        start     = 1'b1;
        start_cyc = cyc;
        first_chk = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input int idx, input int gap, input bit glitch);
        bit ok;
        ok = 1'b0;
        repeat (gap) begin
            ifc.pix_valid = 1'b0;
            @(posedge clk); #1;
        end
        ifc.pix_valid = 1'b1;
        ifc.pix_data  = beats[idx];
        if (glitch) start = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (ifc.pix_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk($sformatf("beat_accept_timeout[%0d]", idx), 256'(0), 256'(1));
            abort = 1'b1;
        end
        @(posedge clk); #1;
        ifc.pix_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int gap_max, input int glitch_beat);
        for (int i = lo; i <= hi && !abort; i++) begin
            send_beat(i, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, i == glitch_beat);
        end
    endtask

    task automatic finish_load(input bit chk_cycles);
        bit got;
        int dcyc;
        got  = 1'b0;
        dcyc = 0;
        for (int w = 0; w < 300 && !abort; w++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                got  = 1'b1;
                dcyc = cyc;
                break;
            end
        end
        chk("done_seen", 256'(got), 256'(1));
        if (got) begin
            chk("busy_at_done", 256'(busy_o), 256'(1));
            if (chk_cycles) chk("start_to_done_cycles", 256'(dcyc - start_cyc + 1), 256'(771));
            @(negedge clk);
            chk("busy_after_done", 256'(busy_o), 256'(0));
            chk("done_single_pulse", 256'(done_o), 256'(0));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 256'(done_cnt), 256'(1));
        compare_sb(192);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] first_line;
        first_line = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

        rst           = 1'b1;
        start         = 1'b0;
        ifc.pix_valid = 1'b0;
        ifc.pix_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 256'(ifc.pix_ready), 256'(0));
        chk("rst_wen", 256'(ifc.mem_wen), 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_done", 256'(done_o), 256'(0));
        chk("rst_addr", 256'(ifc.mem_addr), 256'(0));
        chk("rst_wdata", ifc.mem_wdata, 256'(0));
        @(posedge clk); #1;

        // Continuous stream, no consumer reads: exact timing and first line.
        fill_beats(1'b0);
        start_load();
        send_range(0, 767, 0, -1);
        finish_load(1'b1);
        if (got_addr.size() > 0) begin
            chk("first_addr", 256'(got_addr[0]), 256'(0));
            chk("first_wdata", got_data[0], first_line);
        end

        // Line pending behind 10 cycles of consumer reads.
        fill_beats(1'b0);
        start_load();
        send_range(0, 2, 0, -1);
        busy_force    = 1'b1;
        ifc.pix_valid = 1'b1;
        ifc.pix_data  = beats[3];
        @(negedge clk);
        chk("stall_beat3_ready", 256'(ifc.pix_ready), 256'(1));
        for (int k = 4; k <= 6; k++) begin
            @(posedge clk); #1;
            ifc.pix_data = beats[k];
            @(negedge clk);
            chk($sformatf("stall_beat%0d_ready", k), 256'(ifc.pix_ready), 256'(1));
            chk($sformatf("stall_beat%0d_wen", k), 256'(ifc.mem_wen), 256'(0));
        end
        @(posedge clk); #1;
        ifc.pix_data = beats[7];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("stall_beat7_ready", 256'(ifc.pix_ready), 256'(0));
            chk("stall_wen", 256'(ifc.mem_wen), 256'(0));
            @(posedge clk); #1;
        end
        busy_force = 1'b0;
        @(negedge clk);
        chk("release_wen", 256'(ifc.mem_wen), 256'(1));
        chk("release_addr", 256'(ifc.mem_addr), 256'(0));
        chk("release_ready", 256'(ifc.pix_ready), 256'(1));
        @(posedge clk); #1;
        ifc.pix_valid = 1'b0;
        send_range(8, 767, 0, -1);
        finish_load(1'b0);

        // Random valid gaps and random consumer reads, random pixels.
        for (int r = 0; r < 2; r++) begin
            fill_beats(1'b1);
            busy_rand_en = 1'b1;
            start_load();
            send_range(0, 767, 3, -1);
            busy_rand_en = 1'b0;
            finish_load(1'b0);
        end

        // Start pulsed during luma row 10 must be ignored.
        fill_beats(1'b1);
        start_load();
        send_range(0, 767, 0, 10*8 + 3);
        finish_load(1'b1);

        // Reset after luma row 5 beat 2, then a clean restart.
        fill_beats(1'b1);
        start_load();
        send_range(0, 5*8 + 2, 0, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 256'(ifc.pix_ready), 256'(0));
        chk("midrst_wen", 256'(ifc.mem_wen), 256'(0));
        chk("midrst_busy", 256'(busy_o), 256'(0));
        chk("midrst_done", 256'(done_o), 256'(0));
        chk("midrst_addr", 256'(ifc.mem_addr), 256'(0));
        chk("midrst_wdata", ifc.mem_wdata, 256'(0));
        repeat (3) @(posedge clk);
        #1;
        compare_sb(10);
        fill_beats(1'b1);
        start_load();
        send_range(0, 767, 0, -1);
        finish_load(1'b1);
        if (got_addr.size() > 0) chk("restart_first_addr", 256'(got_addr[0]), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
